// File: rtl/reg_share_arbiter.sv
// Two-port round-robin write sequencer for one shared register.
// States are one-hot so every output is a direct flop bit, with no decode glitches.
//
//  state | meaning
//  ------+---------------------------------------------------------
//  IDLE  | no owner; arbitrate REQ0/REQ1 using the last-served pointer
//  G0    | requester 0 granted; load D0 at the edge if REQ0 still high
//  G1    | requester 1 granted; load D1 at the edge if REQ1 still high
//  A0    | D0 written; one-cycle ACK0
//  A1    | D1 written; one-cycle ACK1
module reg_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             C,
    input  logic             RE,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] D0,
    input  logic [WIDTH-1:0] D1,
    output logic             GNT0,
    output logic             GNT1,
    output logic             ACK0,
    output logic             ACK1,
    output logic [WIDTH-1:0] Q,
    output logic             BUSY
);

    localparam logic [4:0] S_IDLE = 5'b00001;
    localparam logic [4:0] S_G0   = 5'b00010;
    localparam logic [4:0] S_G1   = 5'b00100;
    localparam logic [4:0] S_A0   = 5'b01000;
    localparam logic [4:0] S_A1   = 5'b10000;

    logic [4:0]       state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             last_q, last_d;
    logic             load_en;
    logic             load_sel;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // last_q==1 means port 1 was served last, so port 0 wins a tie
                if (REQ0 && REQ1) state_d = last_q ? S_G0 : S_G1;
                else if (REQ0)    state_d = S_G0;
                else if (REQ1)    state_d = S_G1;
                else              state_d = S_IDLE;
            end
            S_G0:    state_d = REQ0 ? S_A0 : S_IDLE;
            S_G1:    state_d = REQ1 ? S_A1 : S_IDLE;
            S_A0:    state_d = S_IDLE;
            S_A1:    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A dropped request during the grant cycle is an abort: nothing is loaded.
    always_comb begin
        load_en  = ((state_q == S_G0) && REQ0) || ((state_q == S_G1) && REQ1);
        load_sel = (state_q == S_G1);
        q_d      = q_q;
        last_d   = last_q;
        if (load_en) begin
            q_d    = load_sel ? D1 : D0;
            last_d = load_sel;
        end
    end

    always_ff @(posedge C) begin
        if (RE) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            last_q  <= last_d;
        end
    end

    assign GNT0 = state_q[1];
    assign GNT1 = state_q[2];
    assign ACK0 = state_q[3];
    assign ACK1 = state_q[4];
    assign BUSY = ~state_q[0];
    assign Q    = q_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: directed scenarios followed by random requesters.
module tb_reg_share_arbiter;

    logic       C = 1'b0;
    logic       RE = 1'b1;
    logic       REQ0 = 1'b0;
    logic       REQ1 = 1'b0;
    logic [3:0] D0 = '0;
    logic [3:0] D1 = '0;
    logic       GNT0, GNT1, ACK0, ACK1, BUSY;
    logic [3:0] Q;

    int n_checks = 0;
    int n_fail   = 0;

    // expected {GNT0,GNT1,ACK0,ACK1,BUSY,Q} after each rising edge
    logic [8:0] exp_q[$];

    // reference model: transaction owner and phase
    int         m_owner = -1;
    bit         m_acking = 1'b0;
    int         m_last = 1;
    logic [3:0] m_q = '0;

    reg_share_arbiter #(.WIDTH(4)) dut (
        .C(C), .RE(RE), .REQ0(REQ0), .REQ1(REQ1), .D0(D0), .D1(D1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1), .Q(Q), .BUSY(BUSY)
    );

    always #5 C = ~C;

    function automatic void model_step(input logic re, input logic r0, input logic r1,
                                       input logic [3:0] d0v, input logic [3:0] d1v);
        logic       req [2];
        logic [3:0] dat [2];
        logic [8:0] e;
        req[0] = r0; req[1] = r1;
        dat[0] = d0v; dat[1] = d1v;
        if (re) begin
            m_owner = -1; m_acking = 1'b0; m_q = '0; m_last = 1;
        end else if (m_owner < 0) begin
            if (req[0] && req[1]) m_owner = 1 - m_last;
            else if (req[0])      m_owner = 0;
            else if (req[1])      m_owner = 1;
            m_acking = 1'b0;
        end else if (!m_acking) begin
            if (req[m_owner]) begin
                m_q = dat[m_owner]; m_last = m_owner; m_acking = 1'b1;
            end else begin
                m_owner = -1;
            end
        end else begin
            m_owner = -1; m_acking = 1'b0;
        end
        e[8] = (m_owner == 0) && !m_acking;
        e[7] = (m_owner == 1) && !m_acking;
        e[6] = (m_owner == 0) && m_acking;
        e[5] = (m_owner == 1) && m_acking;
        e[4] = (m_owner >= 0);
        e[3:0] = m_q;
        exp_q.push_back(e);
    endfunction

    task automatic apply(input logic re, input logic r0, input logic r1,
                         input logic [3:0] d0v, input logic [3:0] d1v);
        RE = re; REQ0 = r0; REQ1 = r1; D0 = d0v; D1 = d1v;
        model_step(re, r0, r1, d0v, d1v);
    endtask

    task automatic drive(input logic re, input logic r0, input logic r1,
                         input logic [3:0] d0v, input logic [3:0] d1v);
        @(negedge C);
        apply(re, r0, r1, d0v, d1v);
    endtask

    // monitor: compare DUT outputs against the scoreboard just after each edge
    initial begin
        logic [8:0] e, act;
        forever begin
            @(posedge C);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {GNT0, GNT1, ACK0, ACK1, BUSY, Q};
                n_checks++;
                if (act !== e) begin
                    n_fail++;
                    $display("FAIL outputs t=%0t actual gnt=%b%b ack=%b%b busy=%b q=%h required gnt=%b%b ack=%b%b busy=%b q=%h",
                             $time, act[8], act[7], act[6], act[5], act[4], act[3:0],
                             e[8], e[7], e[6], e[5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin
        logic       r0, r1;
        logic [3:0] dd0, dd1;
        logic       re;

        // reset with both requests high, then contention 0,1,0,1
        repeat (2) drive(1, 1, 1, 4'hA, 4'h0);
        repeat (12) drive(0, 1, 1, 4'h3, 4'hC);
        repeat (2) drive(0, 0, 0, 4'h0, 4'h0);

        // single write from port 1
        drive(0, 0, 1, 4'h0, 4'h5);
        drive(0, 0, 1, 4'h0, 4'h5);
        drive(0, 0, 0, 4'h0, 4'h0);
        drive(0, 0, 0, 4'h0, 4'h0);

        // preload 7 via port 0, then abort a port-0 request, then tie goes to port 1
        drive(0, 1, 0, 4'h7, 4'h0);
        drive(0, 1, 0, 4'h7, 4'h0);
        drive(0, 0, 0, 4'h0, 4'h0);
        drive(0, 1, 0, 4'hE, 4'h0);
        drive(0, 0, 0, 4'hE, 4'h0);
        drive(0, 0, 0, 4'h0, 4'h0);
        drive(0, 1, 1, 4'h1, 4'h2);
        drive(0, 1, 1, 4'h1, 4'h2);
        drive(0, 0, 0, 4'h0, 4'h0);
        drive(0, 0, 0, 4'h0, 4'h0);

        // reset during A1 after writing 9, then fresh G1
        drive(0, 0, 1, 4'h0, 4'h9);
        drive(0, 0, 1, 4'h0, 4'h9);
        drive(1, 0, 1, 4'h0, 4'h9);
        drive(0, 0, 1, 4'h0, 4'h9);
        drive(0, 0, 1, 4'h0, 4'h9);
        drive(0, 0, 0, 4'h0, 4'h0);

        // late arrival of REQ0 during A1
        drive(0, 0, 1, 4'h0, 4'hB);
        drive(0, 0, 1, 4'h0, 4'hB);
        drive(0, 1, 0, 4'h6, 4'h0);
        drive(0, 1, 0, 4'h6, 4'h0);
        drive(0, 1, 0, 4'h6, 4'h0);
        drive(0, 0, 0, 4'h0, 4'h0);
        drive(0, 0, 0, 4'h0, 4'h0);

        // random requesters: hold until ACK, occasional aborts and resets
        r0 = 0; r1 = 0; dd0 = '0; dd1 = '0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge C);
            if (r0 && ACK0)                       r0 = 0;
            else if (r0 && $urandom_range(15) == 0) r0 = 0;
            else if (!r0 && $urandom_range(2) == 0) begin
                r0 = 1; dd0 = 4'($urandom);
            end
            if (r1 && ACK1)                       r1 = 0;
            else if (r1 && $urandom_range(15) == 0) r1 = 0;
            else if (!r1 && $urandom_range(2) == 0) begin
                r1 = 1; dd1 = 4'($urandom);
            end
            re = ($urandom_range(63) == 0);
            apply(re, r0, r1, dd0, dd1);
        end
        drive(0, 0, 0, 4'h0, 4'h0);

        repeat (3) @(negedge C);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
